axi_mm_cache_top: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between a simple CPU load/store port and an AXI4 memory-mapped master port.
- Cache line equals one 64-bit AXI beat, so every refill or writeback is a single-beat INCR burst (LEN=0, SIZE=8 bytes).
- Top-level block of the cache subsystem; the AXI master connects to the interconnect or memory slave.

---
 rtl/axi_mm_cache_top.sv | 238 +++++++++++++++++++++++
 tb/tb_axi_mm_cache_top.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mm_cache_top.sv
// Direct-mapped write-back/write-allocate cache: CPU load/store port to a single-beat AXI4 master.
// Define AXI_CACHE_STATS_EN to add the hit_count/miss_count outputs.
module axi_mm_cache_top #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int NUM_LINES      = 32,
  parameter int AXI_ID_VAL     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req_valid,
  output logic                      cpu_req_ready,
  input  logic                      cpu_req_we,
  input  logic [AXI_ADDR_WIDTH-1:0] cpu_req_addr,
  input  logic [AXI_DATA_WIDTH-1:0] cpu_req_wdata,
  input  logic [7:0]                cpu_req_wstrb,
  output logic                      cpu_resp_valid,
  output logic [AXI_DATA_WIDTH-1:0] cpu_resp_rdata,
  output logic                      cpu_resp_err,
`ifdef AXI_CACHE_STATS_EN
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count,
`endif
  output logic [AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic                      M_AXI_AWVALID,
  output logic [AXI_ID_WIDTH-1:0]   M_AXI_AWID,
  output logic [1:0]                M_AXI_AWBURST,
  output logic [2:0]                M_AXI_AWSIZE,
  output logic [7:0]                M_AXI_AWLEN,
  input  logic                      M_AXI_AWREADY,
  output logic [AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [7:0]                M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  output logic                      M_AXI_WLAST,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  input  logic [AXI_ID_WIDTH-1:0]   M_AXI_BID,
  output logic                      M_AXI_BREADY,
  output logic [AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic                      M_AXI_ARVALID,
  output logic [AXI_ID_WIDTH-1:0]   M_AXI_ARID,
  output logic [1:0]                M_AXI_ARBURST,
  output logic [2:0]                M_AXI_ARSIZE,
  output logic [7:0]                M_AXI_ARLEN,
  input  logic                      M_AXI_ARREADY,
  input  logic [AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  input  logic [AXI_ID_WIDTH-1:0]   M_AXI_RID,
  input  logic                      M_AXI_RLAST,
  output logic                      M_AXI_RREADY
);

  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int LINE_W = AXI_ADDR_WIDTH - 3;
  localparam int TAG_W  = LINE_W - IDX_W;

  typedef enum logic [2:0] {IDLE, COMPARE, WB_REQ, WB_RESP, RF_REQ, RF_DATA} state_e;

  state_e                    state_q, state_d;
  logic [NUM_LINES-1:0]      valid_q, dirty_q;
  logic [TAG_W-1:0]          tag_q  [NUM_LINES];
  logic [AXI_DATA_WIDTH-1:0] data_q [NUM_LINES];
  logic [LINE_W-1:0]         reqLine_q;
  logic                      reqWe_q;
  logic [AXI_DATA_WIDTH-1:0] reqWdata_q;
  logic [7:0]                reqWstrb_q;
  logic                      err_q, respValid_q, awDone_q, wDone_q;
  logic [AXI_DATA_WIDTH-1:0] respRdata_q;

  logic [IDX_W-1:0]          reqIdx;
  logic [TAG_W-1:0]          reqTag;
  logic                      hit;
  logic [AXI_DATA_WIDTH-1:0] merged;
  logic                      unusedInputs;

  assign reqIdx = reqLine_q[IDX_W-1:0];
  assign reqTag = reqLine_q[LINE_W-1:IDX_W];
  assign hit    = valid_q[reqIdx] && (tag_q[reqIdx] == reqTag);
  assign unusedInputs = ^{cpu_req_addr[2:0], M_AXI_BID, M_AXI_RID, M_AXI_RLAST};

  always_comb begin
    merged = data_q[reqIdx];
    for (int b = 0; b < 8; b++) begin
      if (reqWstrb_q[b]) merged[8*b +: 8] = reqWdata_q[8*b +: 8];
    end
  end

  assign cpu_resp_valid = respValid_q;
  assign cpu_resp_rdata = respRdata_q;
  assign cpu_resp_err   = err_q;

  assign M_AXI_AWADDR  = {tag_q[reqIdx], reqIdx, 3'b000};
  assign M_AXI_AWID    = AXI_ID_WIDTH'(AXI_ID_VAL);
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWSIZE  = 3'd3;
  assign M_AXI_AWLEN   = 8'd0;
  assign M_AXI_WDATA   = data_q[reqIdx];
  assign M_AXI_WSTRB   = 8'hFF;
  assign M_AXI_WLAST   = 1'b1;
  assign M_AXI_ARADDR  = {reqLine_q, 3'b000};
  assign M_AXI_ARID    = AXI_ID_WIDTH'(AXI_ID_VAL);
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARSIZE  = 3'd3;
  assign M_AXI_ARLEN   = 8'd0;

  always_comb begin
    state_d       = state_q;
    cpu_req_ready = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    case (state_q)
      IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) state_d = COMPARE;
      end
      COMPARE: begin
        if (hit)                                   state_d = IDLE;
        else if (valid_q[reqIdx] && dirty_q[reqIdx]) state_d = WB_REQ;
        else                                       state_d = RF_REQ;
      end
      WB_REQ: begin
        // Address and data channels retire independently; leave once both have handshaken.
        M_AXI_AWVALID = !awDone_q;
        M_AXI_WVALID  = !wDone_q;
        if ((awDone_q || M_AXI_AWREADY) && (wDone_q || M_AXI_WREADY)) state_d = WB_RESP;
      end
      WB_RESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) state_d = RF_REQ;
      end
      RF_REQ: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) state_d = RF_DATA;
      end
      RF_DATA: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) state_d = (M_AXI_RRESP == 2'b00) ? COMPARE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      err_q       <= 1'b0;
      respValid_q <= 1'b0;
      awDone_q    <= 1'b0;
      wDone_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      respValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_req_valid) begin
            reqLine_q  <= cpu_req_addr[AXI_ADDR_WIDTH-1:3];
            reqWe_q    <= cpu_req_we;
            reqWdata_q <= cpu_req_wdata;
            reqWstrb_q <= cpu_req_wstrb;
            err_q      <= 1'b0;
          end
        end
        COMPARE: begin
          if (hit) begin
            respValid_q <= 1'b1;
            respRdata_q <= reqWe_q ? merged : data_q[reqIdx];
            if (reqWe_q) begin
              data_q[reqIdx]  <= merged;
              dirty_q[reqIdx] <= 1'b1;
            end
          end
        end
        WB_REQ: begin
          if (state_d == WB_RESP) begin
            awDone_q <= 1'b0;
            wDone_q  <= 1'b0;
          end else begin
            if (M_AXI_AWVALID && M_AXI_AWREADY) awDone_q <= 1'b1;
            if (M_AXI_WVALID && M_AXI_WREADY)   wDone_q  <= 1'b1;
          end
        end
        WB_RESP: begin
          if (M_AXI_BVALID) begin
            if (M_AXI_BRESP != 2'b00) err_q <= 1'b1;
            dirty_q[reqIdx] <= 1'b0;
          end
        end
        RF_DATA: begin
          if (M_AXI_RVALID) begin
            if (M_AXI_RRESP == 2'b00) begin
              valid_q[reqIdx] <= 1'b1;
              dirty_q[reqIdx] <= 1'b0;
              tag_q[reqIdx]   <= reqTag;
              data_q[reqIdx]  <= M_AXI_RDATA;
            end else begin
              respValid_q <= 1'b1;
              respRdata_q <= '0;
              err_q       <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AXI_CACHE_STATS_EN
  // Only the first COMPARE of a request counts; the post-refill revisit is not a second lookup.
  logic        fromIdle_q;
  logic [31:0] hitCount_q, missCount_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fromIdle_q  <= 1'b0;
      hitCount_q  <= '0;
      missCount_q <= '0;
    end else begin
      fromIdle_q <= (state_q == IDLE) && cpu_req_valid;
      if (state_q == COMPARE && fromIdle_q) begin
        if (hit) hitCount_q  <= hitCount_q + 32'd1;
        else     missCount_q <= missCount_q + 32'd1;
      end
    end
  end

  assign hit_count  = hitCount_q;
  assign miss_count = missCount_q;
`endif

endmodule

// File: tb/tb_axi_mm_cache_top.sv
// Directed bench for axi_mm_cache_top: vector table of CPU requests plus hand-written
// sequences for AW backpressure, refill error and reset during a refill.
module tb_axi_mm_cache_top;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_valid, cpu_req_ready, cpu_req_we;
  logic [31:0] cpu_req_addr;
  logic [63:0] cpu_req_wdata;
  logic [7:0]  cpu_req_wstrb;
  logic        cpu_resp_valid, cpu_resp_err;
  logic [63:0] cpu_resp_rdata;
  logic [31:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WLAST, M_AXI_WREADY;
  logic [3:0]  M_AXI_AWID, M_AXI_ARID, M_AXI_BID, M_AXI_RID;
  logic [1:0]  M_AXI_AWBURST, M_AXI_ARBURST, M_AXI_BRESP, M_AXI_RRESP;
  logic [2:0]  M_AXI_AWSIZE, M_AXI_ARSIZE;
  logic [7:0]  M_AXI_AWLEN, M_AXI_ARLEN, M_AXI_WSTRB;
  logic [63:0] M_AXI_WDATA, M_AXI_RDATA;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RLAST, M_AXI_RREADY;
`ifdef AXI_CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  axi_mm_cache_top dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_we(cpu_req_we),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata), .cpu_req_wstrb(cpu_req_wstrb),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata), .cpu_resp_err(cpu_resp_err),
`ifdef AXI_CACHE_STATS_EN
    .hit_count(hit_count), .miss_count(miss_count),
`endif
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWID(M_AXI_AWID),
    .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWLEN(M_AXI_AWLEN),
    .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WLAST(M_AXI_WLAST), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BID(M_AXI_BID),
    .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARID(M_AXI_ARID),
    .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RID(M_AXI_RID), .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RREADY(M_AXI_RREADY)
  );

  int checks = 0;
  int errors = 0;

  // Slave model state
  logic [63:0] mem [logic [31:0]];
  int          awCount = 0, wCount = 0, bCount = 0, arCount = 0;
  logic [31:0] awAddrSeen, arAddrSeen, awStallAddr;
  logic [63:0] wDataSeen;
  logic        wLastSeen, wFired = 1'b0, rPend = 1'b0, rStall = 1'b0;
  logic [7:0]  wStrbSeen, arLenSeen, awLenSeen;
  logic [2:0]  arSizeSeen, awSizeSeen;
  logic [1:0]  arBurstSeen, awBurstSeen, rErr = 2'b00;
  logic [3:0]  arIdSeen, awIdSeen;
  int          awHold = 0, awStallSeen = 0, awAddrMoved = 0, wReassert = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] expRdata;
    logic        expErr;
    int          expAr;
    logic [31:0] expArAddr;
    int          expAw;
    logic [31:0] expAwAddr;
    logic [63:0] expAwData;
    int          expLat;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                               input logic [7:0] wstrb, output logic [63:0] rdata,
                               output logic err, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!cpu_req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!cpu_req_ready) checkOutput("req_ready_timeout", cpu_req_ready, 1);
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = addr;
    cpu_req_wdata = wdata;
    cpu_req_wstrb = wstrb;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    lat = 1;
    while (!cpu_resp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!cpu_resp_valid) checkOutput("resp_timeout", cpu_resp_valid, 1);
    rdata = cpu_resp_rdata;
    err   = cpu_resp_err;
  endtask

  // Handshake monitor: sees pre-edge values of both sides
  initial begin
    forever begin
      @(posedge clk);
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        awCount++;
        awAddrSeen = M_AXI_AWADDR; awLenSeen = M_AXI_AWLEN; awSizeSeen = M_AXI_AWSIZE;
        awBurstSeen = M_AXI_AWBURST; awIdSeen = M_AXI_AWID;
      end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        wCount++;
        wDataSeen = M_AXI_WDATA; wLastSeen = M_AXI_WLAST; wStrbSeen = M_AXI_WSTRB;
        wFired = 1'b1;
      end
      if (M_AXI_BVALID && M_AXI_BREADY) begin
        bCount++;
        mem[awAddrSeen] = wDataSeen;
        wFired = 1'b0;
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        arCount++;
        arAddrSeen = M_AXI_ARADDR; arLenSeen = M_AXI_ARLEN; arSizeSeen = M_AXI_ARSIZE;
        arBurstSeen = M_AXI_ARBURST; arIdSeen = M_AXI_ARID;
        rPend = 1'b1;
      end
      if (M_AXI_RVALID && M_AXI_RREADY) rPend = 1'b0;
    end
  end

  // Slave response driver, updated on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (M_AXI_AWVALID && awHold > 0) begin
        if (awStallSeen > 0 && M_AXI_AWADDR !== awStallAddr) awAddrMoved++;
        if (wFired && M_AXI_WVALID) wReassert++;
        awStallAddr   = M_AXI_AWADDR;
        M_AXI_AWREADY = 1'b0;
        awHold--;
        awStallSeen++;
      end else begin
        M_AXI_AWREADY = 1'b1;
      end
      M_AXI_BVALID = (bCount < awCount) && (bCount < wCount);
      M_AXI_RVALID = rPend && !rStall;
      M_AXI_RDATA  = mem.exists(arAddrSeen) ? mem[arAddrSeen] : 64'h0;
      M_AXI_RRESP  = rErr;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] rdata;
    logic        err;
    int          lat, ar0, aw0;

    rst = 1'b1;
    cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0; cpu_req_wstrb = '0;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b1; M_AXI_BRESP = 2'b00; M_AXI_BVALID = 1'b0;
    M_AXI_BID = '0; M_AXI_ARREADY = 1'b1; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
    M_AXI_RVALID = 1'b0; M_AXI_RID = '0; M_AXI_RLAST = 1'b1;

    mem[32'h0000_0000] = 64'h1122334455667788;
    mem[32'h0000_0100] = 64'hCAFEF00D12345678;
    mem[32'h0000_0208] = 64'h0123456789ABCDEF;
    mem[32'h0000_0410] = 64'h0BADBEEF0BADBEEF;

    //           we    addr          wdata                   wstrb  expRdata                err   ar  arAddr        aw  awAddr        awData                  lat
    vecs[0] = '{1'b0, 32'h0000_0000, 64'h0,                  8'h00, 64'h1122334455667788, 1'b0, 1, 32'h0000_0000, 0, 32'h0,        64'h0,                  0};
    vecs[1] = '{1'b0, 32'h0000_0000, 64'h0,                  8'h00, 64'h1122334455667788, 1'b0, 0, 32'h0,        0, 32'h0,        64'h0,                  2};
    vecs[2] = '{1'b1, 32'h0000_0000, 64'hAAAAAAAABBBBBBBB,  8'h0F, 64'h11223344BBBBBBBB, 1'b0, 0, 32'h0,        0, 32'h0,        64'h0,                  2};
    vecs[3] = '{1'b0, 32'h0000_0100, 64'h0,                  8'h00, 64'hCAFEF00D12345678, 1'b0, 1, 32'h0000_0100, 1, 32'h0000_0000, 64'h11223344BBBBBBBB, 0};
    vecs[4] = '{1'b0, 32'h0000_0004, 64'h0,                  8'h00, 64'h11223344BBBBBBBB, 1'b0, 1, 32'h0000_0000, 0, 32'h0,        64'h0,                  0};
    vecs[5] = '{1'b1, 32'h0000_0208, 64'hFFFFFFFF00000000,  8'hF0, 64'hFFFFFFFF89ABCDEF, 1'b0, 1, 32'h0000_0208, 0, 32'h0,        64'h0,                  0};
    vecs[6] = '{1'b0, 32'h0000_020C, 64'h0,                  8'h00, 64'hFFFFFFFF89ABCDEF, 1'b0, 0, 32'h0,        0, 32'h0,        64'h0,                  2};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_awvalid", M_AXI_AWVALID, 0);
    checkOutput("rst_wvalid", M_AXI_WVALID, 0);
    checkOutput("rst_arvalid", M_AXI_ARVALID, 0);
    checkOutput("rst_bready", M_AXI_BREADY, 0);
    checkOutput("rst_rready", M_AXI_RREADY, 0);
    checkOutput("rst_req_ready", cpu_req_ready, 1);
    checkOutput("rst_resp_valid", cpu_resp_valid, 0);
    checkOutput("rst_resp_err", cpu_resp_err, 0);

    for (int i = 0; i < NV; i++) begin
      ar0 = arCount;
      aw0 = awCount;
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rdata, err, lat);
      checkOutput($sformatf("v%0d_rdata", i), rdata, vecs[i].expRdata);
      checkOutput($sformatf("v%0d_err", i), err, vecs[i].expErr);
      checkOutput($sformatf("v%0d_ar_count", i), arCount - ar0, vecs[i].expAr);
      checkOutput($sformatf("v%0d_aw_count", i), awCount - aw0, vecs[i].expAw);
      if (vecs[i].expAr > 0) checkOutput($sformatf("v%0d_araddr", i), arAddrSeen, vecs[i].expArAddr);
      if (vecs[i].expAw > 0) begin
        checkOutput($sformatf("v%0d_awaddr", i), awAddrSeen, vecs[i].expAwAddr);
        checkOutput($sformatf("v%0d_wdata", i), wDataSeen, vecs[i].expAwData);
        checkOutput($sformatf("v%0d_wlast", i), wLastSeen, 1);
        checkOutput($sformatf("v%0d_wstrb", i), wStrbSeen, 8'hFF);
      end
      if (vecs[i].expLat > 0) checkOutput($sformatf("v%0d_latency", i), lat, vecs[i].expLat);
    end

    checkOutput("arlen", arLenSeen, 0);
    checkOutput("arsize", arSizeSeen, 3);
    checkOutput("arburst", arBurstSeen, 1);
    checkOutput("arid", arIdSeen, 0);
    checkOutput("awlen", awLenSeen, 0);
    checkOutput("awsize", awSizeSeen, 3);
    checkOutput("awburst", awBurstSeen, 1);
    checkOutput("awid", awIdSeen, 0);

    // AW held off for 5 cycles while W is accepted immediately
    applyStimulus(1'b1, 32'h0000_0000, 64'h5555555555555555, 8'hFF, rdata, err, lat);
    checkOutput("bp_store_rdata", rdata, 64'h5555555555555555);
    awHold = 5; awStallSeen = 0; awAddrMoved = 0; wReassert = 0;
    aw0 = awCount;
    applyStimulus(1'b0, 32'h0000_0100, 64'h0, 8'h00, rdata, err, lat);
    checkOutput("bp_stall_cycles", awStallSeen, 5);
    checkOutput("bp_wvalid_dropped", wReassert, 0);
    checkOutput("bp_awaddr_stable", awAddrMoved, 0);
    checkOutput("bp_aw_count", awCount - aw0, 1);
    checkOutput("bp_awaddr", awAddrSeen, 32'h0);
    checkOutput("bp_wdata", wDataSeen, 64'h5555555555555555);
    checkOutput("bp_rdata", rdata, 64'hCAFEF00D12345678);
    checkOutput("bp_mem_written", mem[32'h0], 64'h5555555555555555);

    // Refill error: no install, so the retry must go back to memory
    rErr = 2'b10;
    applyStimulus(1'b0, 32'h0000_0410, 64'h0, 8'h00, rdata, err, lat);
    checkOutput("rerr_err", err, 1);
    checkOutput("rerr_rdata", rdata, 64'h0);
    rErr = 2'b00;
    ar0 = arCount;
    applyStimulus(1'b0, 32'h0000_0410, 64'h0, 8'h00, rdata, err, lat);
    checkOutput("rerr_retry_ar", arCount - ar0, 1);
    checkOutput("rerr_retry_rdata", rdata, 64'h0BADBEEF0BADBEEF);
    checkOutput("rerr_retry_err", err, 0);

    // Reset while waiting for R
    rStall = 1'b1;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 32'h0000_0510;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    for (int k = 0; k < 50 && !M_AXI_RREADY; k++) @(negedge clk);
    checkOutput("mid_rf_data_reached", M_AXI_RREADY, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rPend = 1'b0;
    rStall = 1'b0;
    checkOutput("mid_rst_rready", M_AXI_RREADY, 0);
    checkOutput("mid_rst_arvalid", M_AXI_ARVALID, 0);
    checkOutput("mid_rst_req_ready", cpu_req_ready, 1);
    checkOutput("mid_rst_resp_valid", cpu_resp_valid, 0);
    ar0 = arCount;
    applyStimulus(1'b0, 32'h0000_0000, 64'h0, 8'h00, rdata, err, lat);
    checkOutput("post_rst_miss_ar", arCount - ar0, 1);
    checkOutput("post_rst_rdata", rdata, 64'h5555555555555555);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
